// File: rtl/pulse_width_meter_pkg.sv
// Shared definitions for the pulse width meter: FSM state codes and default counter width.
// Optional input synchronizer is selected with the PULSE_METER_SYNC_EN macro.
package pulse_width_meter_pkg;

    localparam int DEFAULT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pulse_width_meter_edge_detect.sv
// Samples pulse_in (optionally through a 2-flop synchronizer when PULSE_METER_SYNC_EN
// is defined) and produces the sampled level plus rise/fall qualifiers.
module pulse_width_meter_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic pulse_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic s_q;
    logic prev_q;

`ifdef PULSE_METER_SYNC_EN
    logic sync1_q;
    logic sync2_q;

    // Every stage resets high so a line already high at reset never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            s_q     <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= pulse_in;
            sync2_q <= sync1_q;
            s_q     <= sync2_q;
            prev_q  <= s_q;
        end
    end
`else
    // Both sample and history reset high so a line already high at reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q    <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s_q    <= pulse_in;
            prev_q <= s_q;
        end
    end
`endif

    assign s    = s_q;
    assign rise = s_q & ~prev_q;
    assign fall = ~s_q & prev_q;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures the high time of pulse_in in clk cycles and reports it once per pulse.
// Build option: PULSE_METER_SYNC_EN adds a 2-flop input synchronizer (+2 cycles latency).
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pulse_in,
    input  logic [W-1:0] expected,
    output logic [W-1:0] width,
    output logic         valid,
    output logic         match,
    output logic         overflow,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic   s;
    logic   rise;
    logic   fall;
    state_t state;
    state_t state_nxt;

    logic [W-1:0] count;
    logic         sat;

    pulse_width_meter_edge_detect u_edge (
        .clk      (clk),
        .rst      (rst),
        .pulse_in (pulse_in),
        .s        (s),
        .rise     (rise),
        .fall     (fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE is a single cycle, but a rise during it starts the next measurement directly.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (rise) state_nxt = ST_MEAS;
            ST_MEAS: if (fall) state_nxt = ST_DONE;
            ST_DONE: state_nxt = rise ? ST_MEAS : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == ST_MEAS);
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            sat      <= 1'b0;
            width    <= '0;
            valid    <= 1'b0;
            match    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (rise) begin
                        count <= CNT_ONE;
                        sat   <= 1'b0;
                    end
                end
                ST_MEAS: begin
                    if (fall) begin
                        width    <= count;
                        overflow <= sat;
                        match    <= (count == expected) && !sat;
                        valid    <= 1'b1;
                    end else if (s) begin
                        // Counter pins at its maximum; sat records that a cycle was lost.
                        if (count == CNT_MAX) begin
                            sat <= 1'b1;
                        end else begin
                            count <= count + CNT_ONE;
                        end
                    end
                end
                default: begin
                    count <= '0;
                    sat   <= 1'b0;
                end
            endcase
        end
    end

endmodule
